window_sum_ctrl: RTL and testbench

WINDOW_SUM_CTRL -- requirements
Module: window_sum_ctrl

---
 rtl/window_sum_ctrl.sv | 134 +++++++++++++
 tb/tb_window_sum_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_sum_ctrl.sv
// Round-robin two-client RAM write arbiter plus a windowed read-and-sum engine.
// Define WSC_WRITE_BLOCK_EN to hold off writes to window words not yet read by the engine.
module window_sum_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int WIN_LEN = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_gnt,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_gnt,
  input  logic              sum_start,
  input  logic [ADDR_W-1:0] sum_base,
  output logic              sum_busy,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [DATA_W+3:0] sum_out,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_di,
  output logic [ADDR_W-1:0] ram_dpra,
  input  logic [DATA_W-1:0] ram_dpo
);

  localparam int ACC_W = DATA_W + 4;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic              busy_r;
  logic              valid_r;
  logic              ptr;
  logic              blk0, blk1;
  logic              elig0, elig1;
  logic              gnt0, gnt1;

`ifdef WSC_WRITE_BLOCK_EN
  // True when address a sits in the window at an offset the engine has not read yet.
  function automatic logic in_unread(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b,
                                     input logic [CNT_W-1:0]  c);
    logic [ADDR_W-1:0] off;
    off = a - b;
    return (32'(off) < 32'(WIN_LEN)) && (32'(off) >= 32'(c));
  endfunction

  always_comb begin
    blk0 = (state == ACCUM) && in_unread(wr0_addr, base, cnt);
    blk1 = (state == ACCUM) && in_unread(wr1_addr, base, cnt);
  end
`else
  assign blk0 = 1'b0;
  assign blk1 = 1'b0;
`endif

  // ptr == 0 favours client 0 when both clients are eligible.
  always_comb begin
    elig0 = wr0_req & ~blk0 & ~rst;
    elig1 = wr1_req & ~blk1 & ~rst;
    gnt0  = elig0 & (~elig1 | ~ptr);
    gnt1  = elig1 & (~elig0 | ptr);
  end

  assign wr0_gnt = gnt0;
  assign wr1_gnt = gnt1;
  assign ram_we  = gnt0 | gnt1;
  assign ram_a   = gnt0 ? wr0_addr : (gnt1 ? wr1_addr : '0);
  assign ram_di  = gnt0 ? wr0_data : (gnt1 ? wr1_data : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (gnt0) begin
      ptr <= 1'b1;
    end else if (gnt1) begin
      ptr <= 1'b0;
    end
  end

  assign ram_dpra  = (state == ACCUM) ? base + ADDR_W'(cnt) : base;
  assign sum_busy  = busy_r;
  assign sum_valid = valid_r;
  assign sum_out   = valid_r ? acc : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      cnt     <= '0;
      acc     <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sum_start) begin
            base   <= sum_base;
            cnt    <= '0;
            acc    <= '0;
            busy_r <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(ram_dpo);
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIN_LEN - 1)) begin
            valid_r <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (sum_ready) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_sum_ctrl.sv
// Scoreboard bench for window_sum_ctrl with a behavioural dual-port RAM model.
module tb_window_sum_ctrl;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int WIN    = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr0_req = 1'b0, wr1_req = 1'b0;
  logic [ADDR_W-1:0] wr0_addr = '0, wr1_addr = '0;
  logic [DATA_W-1:0] wr0_data = '0, wr1_data = '0;
  logic              wr0_gnt, wr1_gnt;
  logic              sum_start = 1'b0;
  logic [ADDR_W-1:0] sum_base = '0;
  logic              sum_busy, sum_valid;
  logic              sum_ready = 1'b0;
  logic [DATA_W+3:0] sum_out;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_a, ram_dpra;
  logic [DATA_W-1:0] ram_di, ram_dpo;

  logic [DATA_W-1:0] mem [DEPTH];
  int sb [$];
  int n_run  = 0;
  int n_fail = 0;

  window_sum_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WIN_LEN(WIN)) dut (
    .clk(clk), .rst(rst),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .sum_start(sum_start), .sum_base(sum_base), .sum_busy(sum_busy),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_out(sum_out),
    .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_dpra(ram_dpra), .ram_dpo(ram_dpo)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_di;
  end

  assign ram_dpo = mem[ram_dpra];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int win_sum(input int b);
    int s;
    s = 0;
    for (int i = 0; i < WIN; i++) s += int'(mem[(b + i) % DEPTH]);
    return s;
  endfunction

  task automatic pop_check();
    if (sb.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
    else check_eq("sum", 32'(sum_out), 32'(sb.pop_front()));
  endtask

  // Called at a negedge; one single-requester write per cycle.
  task automatic load(input int a, input int d);
    wr0_req = 1'b1; wr0_addr = ADDR_W'(a); wr0_data = DATA_W'(d);
    #1 check_eq("single_gnt0", 32'(wr0_gnt), 32'd1);
    @(negedge clk);
    wr0_req = 1'b0;
  endtask

  task automatic run_sum(input int b, input int hold);
    int cyc;
    sb.push_back(win_sum(b));
    sum_start = 1'b1; sum_base = ADDR_W'(b);
    @(negedge clk);
    sum_start = 1'b0;
    #1 check_eq("busy_accum", 32'(sum_busy), 32'd1);
    cyc = 1;
    while (!sum_valid && cyc <= 4 * WIN) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(WIN + 1));
    for (int k = 0; k < hold; k++) begin
      sum_start = k[0]; sum_base = 6'd33;
      @(negedge clk);
      #1;
      check_eq("hold_valid", 32'(sum_valid), 32'd1);
      if (sb.size() != 0) check_eq("hold_out", 32'(sum_out), 32'(sb[0]));
    end
    sum_start = 1'b0;
    sum_ready = 1'b1;
    #1 check_eq("hs_busy", 32'(sum_busy), 32'd1);
    pop_check();
    @(negedge clk);
    sum_ready = 1'b0;
    #1;
    check_eq("idle_busy", 32'(sum_busy), 32'd0);
    check_eq("idle_valid", 32'(sum_valid), 32'd0);
    check_eq("idle_out", 32'(sum_out), 32'd0);
  endtask

  // Client 0 starts requesting address a in ACCUM cycle wcyc of a base-0 window.
  task automatic write_during(input int a, input int d, input int wcyc);
    int old_v, exp_s, gexp, gcyc, cyc;
    bit got;
    old_v = int'(mem[a]);
    exp_s = win_sum(0);
`ifdef WSC_WRITE_BLOCK_EN
    gexp = (a >= wcyc && a < WIN) ? a + 1 : wcyc;
`else
    gexp = wcyc;
    if (a > wcyc && a < WIN) exp_s = exp_s - old_v + d;
`endif
    sb.push_back(exp_s);
    sum_start = 1'b1; sum_base = '0;
    @(negedge clk);
    sum_start = 1'b0;
    cyc = 0; got = 1'b0; gcyc = -1;
    while (!sum_valid && cyc < 4 * WIN) begin
      if (cyc == wcyc) begin
        wr0_req = 1'b1; wr0_addr = ADDR_W'(a); wr0_data = DATA_W'(d);
      end
      #1;
      if (wr0_req && wr0_gnt && !got) begin
        got = 1'b1; gcyc = cyc;
      end
      @(negedge clk);
      if (got) wr0_req = 1'b0;
      cyc++;
    end
    wr0_req = 1'b0;
    check_eq("wr_gnt_cyc", 32'(gcyc), 32'(gexp));
    check_eq("wr_latency", 32'(cyc), 32'(WIN));
    sum_ready = 1'b1;
    #1 pop_check();
    @(negedge clk);
    sum_ready = 1'b0;
  endtask

  task automatic check_all_zero();
    check_eq("rst_gnt0", 32'(wr0_gnt), 32'd0);
    check_eq("rst_gnt1", 32'(wr1_gnt), 32'd0);
    check_eq("rst_we", 32'(ram_we), 32'd0);
    check_eq("rst_a", 32'(ram_a), 32'd0);
    check_eq("rst_di", 32'(ram_di), 32'd0);
    check_eq("rst_dpra", 32'(ram_dpra), 32'd0);
    check_eq("rst_busy", 32'(sum_busy), 32'd0);
    check_eq("rst_valid", 32'(sum_valid), 32'd0);
    check_eq("rst_out", 32'(sum_out), 32'd0);
  endtask

  initial begin
    int seen;
    wr0_req = 1'b1; wr0_addr = 6'd40; wr0_data = 8'h11;
    wr1_req = 1'b1; wr1_addr = 6'd41; wr1_data = 8'h22;
    repeat (3) @(negedge clk);
    #1 check_all_zero();

    // Both clients contend from reset: 0,1,0,1.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_gnt0", 32'(wr0_gnt), 32'(i % 2 == 0));
      check_eq("rr_gnt1", 32'(wr1_gnt), 32'(i % 2 == 1));
      check_eq("rr_we", 32'(ram_we), 32'd1);
      check_eq("rr_a", 32'(ram_a), (i % 2 == 0) ? 32'd40 : 32'd41);
      check_eq("rr_di", 32'(ram_di), (i % 2 == 0) ? 32'h11 : 32'h22);
      @(negedge clk);
    end
    wr0_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 check_eq("single_gnt1", 32'(wr1_gnt), 32'd1);
      @(negedge clk);
    end
    wr1_req = 1'b0;
    #1 check_eq("idle_we", 32'(ram_we), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) load(i, i + 1);
    run_sum(0, 0);

    load(62, 8'hFF);
    load(63, 8'hFF);
    for (int i = 0; i < 8; i++) load(i, 8'hFF);
    run_sum(62, 5);

    write_during(5, 8'h01, 2);
    write_during(5, 8'h33, 5);

    // Reset in the fourth read of a window discards it.
    sum_start = 1'b1; sum_base = 6'd0;
    @(negedge clk);
    sum_start = 1'b0;
    repeat (3) @(negedge clk);
    wr0_req = 1'b1; wr1_req = 1'b1;
    rst = 1'b1;
    #1 check_all_zero();
    @(negedge clk);
    rst = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 2 * WIN; i++) begin
      @(negedge clk);
      if (sum_valid) seen++;
    end
    check_eq("no_valid_after_rst", 32'(seen), 32'd0);

    // Reset during HOLD, then start on the very first edge after release.
    sum_start = 1'b1; sum_base = 6'd60;
    @(negedge clk);
    sum_start = 1'b0;
    repeat (WIN + 2) @(negedge clk);
    #1 check_eq("hold_before_rst", 32'(sum_valid), 32'd1);
    rst = 1'b1;
    #1 check_eq("rst_hold_valid", 32'(sum_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sum(3, 1);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
